packet_serial_tx: RTL

// - Transmit side of the serial packet link. Drains payload bytes from a FIFO and emits

---
 rtl/packet_serial_tx_if.sv | 22 ++
 rtl/packet_serial_tx.sv | 138 +++++++++++++
 2 files changed

// File: rtl/packet_serial_tx_if.sv
// Link between the payload FIFO read port, the serial line and the packet transmitter.
// The master modport is the transmitter; the slave modport is the FIFO/line side.
interface packet_serial_tx_if;
  logic       hdr_sel;
  logic       fifo_empty;
  logic [7:0] fifo_rdata;
  logic       fifo_rd;
  logic       serial_data;
  logic       data_ena;
  logic       busy;
  logic       pkt_done;

  modport master (
    input  hdr_sel, fifo_empty, fifo_rdata,
    output fifo_rd, serial_data, data_ena, busy, pkt_done
  );

  modport slave (
    output hdr_sel, fifo_empty, fifo_rdata,
    input  fifo_rd, serial_data, data_ena, busy, pkt_done
  );
endinterface

// File: rtl/packet_serial_tx.sv
// Serial packet transmitter: one header byte, then BYTES_PER_PKT payload bytes popped
// from the FIFO, each sent MSB first during an 8-cycle data_ena burst.
module packet_serial_tx #(
  parameter logic [7:0] HDR_A         = 8'hA5,
  parameter logic [7:0] HDR_B         = 8'hC3,
  parameter int         BYTES_PER_PKT = 4,
  parameter int         GAP_CYCLES    = 2
) (
  input  logic                 clk_50,
  input  logic                 reset_n,
  packet_serial_tx_if.master   link
);

  localparam int BCW = $clog2(BYTES_PER_PKT + 1);
  localparam int GCW = $clog2(GAP_CYCLES + 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BYTES_PER_PKT);
  localparam logic [GCW-1:0] GAP_LOAD  = GCW'(GAP_CYCLES - 1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_HDR_LOAD = 3'd1;
  localparam logic [2:0] ST_SHIFT    = 3'd2;
  localparam logic [2:0] ST_GAP      = 3'd3;
  localparam logic [2:0] ST_FETCH    = 3'd4;
  localparam logic [2:0] ST_RDWAIT   = 3'd5;
  localparam logic [2:0] ST_DONE     = 3'd6;

  logic [2:0]     state_r;
  logic [7:0]     hdr_r;
  logic [7:0]     shreg_r;
  logic [2:0]     bitcnt_r;
  logic [BCW-1:0] bytecnt_r;
  logic [GCW-1:0] gapcnt_r;

  logic fifo_rd_s;
  logic serial_data_s;
  logic data_ena_s;
  logic busy_s;
  logic pkt_done_s;

  // Packet sequencing: header latch, shift register, bit/byte/gap counters.
  always_ff @(posedge clk_50) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      hdr_r     <= 8'h00;
      shreg_r   <= 8'h00;
      bitcnt_r  <= 3'd0;
      bytecnt_r <= {BCW{1'b0}};
      gapcnt_r  <= {GCW{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!link.fifo_empty) begin
            hdr_r   <= link.hdr_sel ? HDR_B : HDR_A;
            state_r <= ST_HDR_LOAD;
          end
        end
        ST_HDR_LOAD: begin
          shreg_r   <= hdr_r;
          bitcnt_r  <= 3'd0;
          bytecnt_r <= {BCW{1'b0}};
          state_r   <= ST_SHIFT;
        end
        ST_SHIFT: begin
          shreg_r  <= {shreg_r[6:0], 1'b0};
          bitcnt_r <= bitcnt_r + 3'd1;
          if (bitcnt_r == 3'd7) begin
            gapcnt_r <= GAP_LOAD;
            state_r  <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gapcnt_r == {GCW{1'b0}}) begin
            state_r <= (bytecnt_r == LAST_BYTE) ? ST_DONE : ST_FETCH;
          end else begin
            gapcnt_r <= gapcnt_r - GCW'(1'b1);
          end
        end
        ST_FETCH: begin
          // An empty FIFO here is an underflow stall: the gap simply stretches.
          if (!link.fifo_empty) begin
            state_r <= ST_RDWAIT;
          end
        end
        ST_RDWAIT: begin
          shreg_r   <= link.fifo_rdata;
          bytecnt_r <= bytecnt_r + BCW'(1'b1);
          bitcnt_r  <= 3'd0;
          state_r   <= ST_SHIFT;
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Output decode from state and shift register; only fifo_rd looks at an input.
  always_comb begin
    fifo_rd_s     = 1'b0;
    serial_data_s = 1'b0;
    data_ena_s    = 1'b0;
    busy_s        = 1'b0;
    pkt_done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy_s = 1'b0;
      end
      ST_HDR_LOAD, ST_GAP, ST_RDWAIT: begin
        busy_s = 1'b1;
      end
      ST_SHIFT: begin
        busy_s        = 1'b1;
        data_ena_s    = 1'b1;
        serial_data_s = shreg_r[7];
      end
      ST_FETCH: begin
        busy_s    = 1'b1;
        fifo_rd_s = !link.fifo_empty;
      end
      ST_DONE: begin
        pkt_done_s = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign link.fifo_rd     = fifo_rd_s;
  assign link.serial_data = serial_data_s;
  assign link.data_ena    = data_ena_s;
  assign link.busy        = busy_s;
  assign link.pkt_done    = pkt_done_s;

endmodule
